// File: rtl/pic_multi_if.sv
// I/O bus between the CPU and the interrupt controller.
// Toggle handshake: request and acknowledge toggles plus address/data.
interface pic_multi_if;
    logic [11:0] port;
    logic [15:0] din;
    logic [15:0] dout;
    logic        cpu_iordin;
    logic        cpu_iordout;
    logic        cpu_iowrin;
    logic        cpu_iowrout;

    modport master (
        output port, din, cpu_iordin, cpu_iowrin,
        input  dout, cpu_iordout, cpu_iowrout
    );

    modport slave (
        input  port, din, cpu_iordin, cpu_iowrin,
        output dout, cpu_iordout, cpu_iowrout
    );
endinterface

// File: rtl/pic_multi.sv
// Multi-line programmable interrupt controller: IMR/IRR/ISR, per-line
// edge/level mode, fixed priority (line 0 highest), EOI commands.
module pic_multi #(
    parameter int          NUM_IRQ     = 8,
    parameter logic [7:0]  VECTOR_BASE = 8'h08,
    parameter logic [11:0] BASE_PORT   = 12'h020,
    parameter logic [7:0]  EDGE_RESET  = 8'h01
) (
    input  logic               clk,
    input  logic               reset_n,
    pic_multi_if.slave         bus,
    input  logic               inta,
    output logic [7:0]         irq_vector,
    output logic               intr,
    input  logic [NUM_IRQ-1:0] irq
);

    logic [NUM_IRQ-1:0] r_irr;
    logic [NUM_IRQ-1:0] r_isr;
    logic [NUM_IRQ-1:0] r_imr;
    logic [NUM_IRQ-1:0] r_elcr;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic               r_intr;
    logic [7:0]         r_vec;
    logic [15:0]        r_dout;
    logic               r_rd_ack;
    logic               r_wr_ack;

    logic               w_rd_act;
    logic               w_wr_act;
    logic               w_sel0;
    logic               w_sel1;
    logic               w_sel2;
    logic               w_eoi_ns;
    logic               w_eoi_sp;
    logic [NUM_IRQ-1:0] w_pend;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_isr_set;
    logic [NUM_IRQ-1:0] w_irr_clr;
    logic [NUM_IRQ-1:0] w_eoi_clr;
    logic [NUM_IRQ-1:0] w_irr_nxt;
    logic [NUM_IRQ-1:0] w_isr_nxt;
    logic               w_isr_any;
    logic [2:0]         w_isr_lo;
    logic               w_cand;
    logic [2:0]         w_cand_idx;
    logic [7:0]         w_irr8;
    logic [7:0]         w_isr8;
    logic [7:0]         w_imr8;
    logic [7:0]         w_elcr8;
    logic [15:0]        w_rdata;
    logic [7:0]         w_vec_nxt;
    logic               w_unused;

    assign w_rd_act = bus.cpu_iordin != r_rd_ack;
    assign w_wr_act = bus.cpu_iowrin != r_wr_ack;
    assign w_sel0   = bus.port == BASE_PORT;
    assign w_sel1   = bus.port == BASE_PORT + 12'd1;
    assign w_sel2   = bus.port == BASE_PORT + 12'd2;
    assign w_eoi_ns = w_wr_act && w_sel0 && bus.din[7:5] == 3'b001;
    assign w_eoi_sp = w_wr_act && w_sel0 && bus.din[7:5] == 3'b011;
    assign w_pend   = r_irr & ~r_imr;
    assign w_edge   = irq & ~r_irq_prev;
    assign w_unused = &{1'b0, bus.din};

    // Downward scans so the lowest index found is the one that sticks.
    always_comb begin
        w_isr_any  = 1'b0;
        w_isr_lo   = 3'd0;
        for (int n = NUM_IRQ - 1; n >= 0; n--) begin
            if (r_isr[n]) begin
                w_isr_any = 1'b1;
                w_isr_lo  = 3'(n);
            end
        end
        w_cand     = 1'b0;
        w_cand_idx = 3'd0;
        for (int n = NUM_IRQ - 1; n >= 0; n--) begin
            if (w_pend[n] && (!w_isr_any || 3'(n) < w_isr_lo)) begin
                w_cand     = 1'b1;
                w_cand_idx = 3'(n);
            end
        end
    end

    always_comb begin
        w_eoi_clr = '0;
        w_isr_set = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            w_eoi_clr[n] = (w_eoi_ns && w_isr_any && w_isr_lo == 3'(n))
                        || (w_eoi_sp && bus.din[2:0] == 3'(n));
            w_isr_set[n] = inta && w_cand && w_cand_idx == 3'(n);
        end
        w_irr_clr = w_isr_set & r_elcr;
        // A fresh edge beats the acknowledge clear on the same line.
        for (int n = 0; n < NUM_IRQ; n++) begin
            w_irr_nxt[n] = r_elcr[n]
                ? ((r_irr[n] & ~w_irr_clr[n]) | w_edge[n])
                : irq[n];
        end
        w_isr_nxt = (r_isr & ~w_eoi_clr) | w_isr_set;
    end

    always_comb begin
        w_irr8  = '0;
        w_isr8  = '0;
        w_imr8  = '0;
        w_elcr8 = '0;
        w_irr8[NUM_IRQ-1:0]  = r_irr;
        w_isr8[NUM_IRQ-1:0]  = r_isr;
        w_imr8[NUM_IRQ-1:0]  = r_imr;
        w_elcr8[NUM_IRQ-1:0] = r_elcr;
        if (w_sel0)
            w_rdata = {w_isr8, w_irr8};
        else if (w_sel1)
            w_rdata = {8'h00, w_imr8};
        else if (w_sel2)
            w_rdata = {8'h00, w_elcr8};
        else
            w_rdata = 16'hFFFF;
    end

    assign w_vec_nxt = w_cand ? VECTOR_BASE + {5'd0, w_cand_idx}
                              : VECTOR_BASE + 8'(NUM_IRQ - 1);

    always_ff @(posedge clk) begin
        r_rd_ack   <= bus.cpu_iordin;
        r_wr_ack   <= bus.cpu_iowrin;
        r_irq_prev <= irq;
        if (!reset_n) begin
            r_irr  <= '0;
            r_isr  <= '0;
            r_imr  <= '1;
            r_elcr <= EDGE_RESET[NUM_IRQ-1:0];
            r_intr <= 1'b0;
            r_vec  <= 8'h00;
            r_dout <= 16'hFFFF;
        end else begin
            r_irr  <= w_irr_nxt;
            r_isr  <= w_isr_nxt;
            r_intr <= inta ? 1'b0 : w_cand;
            if (w_wr_act && w_sel1)
                r_imr <= bus.din[NUM_IRQ-1:0];
            if (w_wr_act && w_sel2)
                r_elcr <= bus.din[NUM_IRQ-1:0];
            if (inta)
                r_vec <= w_vec_nxt;
            if (w_rd_act)
                r_dout <= w_rdata;
        end
    end

    assign bus.dout        = r_dout;
    assign bus.cpu_iordout = r_rd_ack;
    assign bus.cpu_iowrout = r_wr_ack;
    assign irq_vector      = r_vec;
    assign intr            = r_intr;

endmodule

// File: tb/tb_pic_multi.sv
// Directed bench for pic_multi: capture, nesting, EOI, modes,
// spurious acknowledge, register access and reset.
module tb_pic_multi;

    localparam logic [11:0] B = 12'h020;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       inta = 1'b0;
    logic [7:0] irq = 8'h00;
    wire  [7:0] irq_vector;
    wire        intr;

    int n_chk = 0;
    int n_fail = 0;

    pic_multi_if bus();

    pic_multi dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .inta       (inta),
        .irq_vector (irq_vector),
        .intr       (intr),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_write(input logic [11:0] p, input logic [15:0] d);
        bus.port = p;
        bus.din = d;
        bus.cpu_iowrin = ~bus.cpu_iowrin;
        @(negedge clk);
        chk("wr_ack", 16'(bus.cpu_iowrout), 16'(bus.cpu_iowrin));
    endtask

    task automatic io_read(input string tag, input logic [11:0] p,
                           input logic [15:0] exp);
        bus.port = p;
        bus.cpu_iordin = ~bus.cpu_iordin;
        @(negedge clk);
        chk("rd_ack", 16'(bus.cpu_iordout), 16'(bus.cpu_iordin));
        chk(tag, bus.dout, exp);
    endtask

    task automatic do_inta;
        inta = 1'b1;
        @(negedge clk);
        inta = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.port = 12'h000;
        bus.din = 16'h0000;
        bus.cpu_iordin = 1'b0;
        bus.cpu_iowrin = 1'b0;
        cycles(3);
        chk("rst_intr", 16'(intr), 16'h0000);
        chk("rst_vec", 16'(irq_vector), 16'h0000);
        chk("rst_dout", bus.dout, 16'hFFFF);
        reset_n = 1'b1;
        cycles(1);
        io_read("rst_sr", B, 16'h0000);
        io_read("rst_imr", B + 12'd1, 16'h00FF);
        io_read("rst_elcr", B + 12'd2, 16'h0001);
        io_read("unmapped", 12'h030, 16'hFFFF);

        // edge capture on line 0
        io_write(B + 12'd1, 16'h0000);
        irq[0] = 1'b1;
        cycles(1);
        chk("lat_t1", 16'(intr), 16'h0000);
        cycles(1);
        chk("lat_t2", 16'(intr), 16'h0001);
        irq[0] = 1'b0;
        do_inta();
        chk("ack0_vec", 16'(irq_vector), 16'h0008);
        chk("ack0_intr", 16'(intr), 16'h0000);
        io_read("ack0_sr", B, 16'h0100);
        io_write(B, 16'h0020);
        io_read("eoi0_sr", B, 16'h0000);

        // nesting: line 3 in service, 5 blocked, 1 preempts
        irq[3] = 1'b1;
        cycles(2);
        chk("l3_intr", 16'(intr), 16'h0001);
        do_inta();
        irq[3] = 1'b0;
        chk("l3_vec", 16'(irq_vector), 16'h000B);
        irq[5] = 1'b1;
        cycles(3);
        chk("l5_blk", 16'(intr), 16'h0000);
        io_read("nest_sr", B, 16'h0820);
        irq[1] = 1'b1;
        cycles(2);
        chk("l1_intr", 16'(intr), 16'h0001);
        do_inta();
        irq[1] = 1'b0;
        irq[5] = 1'b0;
        chk("l1_vec", 16'(irq_vector), 16'h0009);
        cycles(2);
        chk("nest_intr", 16'(intr), 16'h0000);
        io_read("nest_sr2", B, 16'h0A00);

        // EOI commands
        io_write(B, 16'h0020);
        io_read("eoi_ns", B, 16'h0800);
        io_write(B, 16'h0063);
        io_read("eoi_sp", B, 16'h0000);

        // line 1 edge: held level fires once only
        io_write(B + 12'd2, 16'h0002);
        irq[1] = 1'b1;
        cycles(2);
        chk("e1_intr", 16'(intr), 16'h0001);
        do_inta();
        io_write(B, 16'h0020);
        cycles(3);
        chk("e1_once", 16'(intr), 16'h0000);
        io_read("e1_sr", B, 16'h0000);

        // switch line 1 to level: IRR reloads from live level
        io_write(B + 12'd2, 16'h0000);
        cycles(2);
        chk("lv_intr", 16'(intr), 16'h0001);
        do_inta();
        chk("lv_vec", 16'(irq_vector), 16'h0009);
        io_write(B, 16'h0020);
        cycles(2);
        chk("lv_reassert", 16'(intr), 16'h0001);
        irq[1] = 1'b0;
        cycles(2);
        chk("lv_drop", 16'(intr), 16'h0000);
        io_read("lv_sr", B, 16'h0000);

        // spurious acknowledge
        do_inta();
        chk("spur_vec", 16'(irq_vector), 16'h000F);
        io_read("spur_sr", B, 16'h0000);

        // register access then reset mid-read
        io_write(B + 12'd1, 16'h00A5);
        io_read("unmapped2", 12'h030, 16'hFFFF);
        io_read("imr_a5", B + 12'd1, 16'h00A5);
        io_read("elcr_0", B + 12'd2, 16'h0000);
        bus.port = B + 12'd1;
        bus.cpu_iordin = ~bus.cpu_iordin;
        reset_n = 1'b0;
        irq[0] = 1'b1;
        @(negedge clk);
        chk("mr_ack", 16'(bus.cpu_iordout), 16'(bus.cpu_iordin));
        chk("mr_dout", bus.dout, 16'hFFFF);
        chk("mr_vec", 16'(irq_vector), 16'h0000);
        reset_n = 1'b1;
        cycles(2);
        io_read("post_sr", B, 16'h0000);
        io_read("post_imr", B + 12'd1, 16'h00FF);
        io_read("post_elcr", B + 12'd2, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
